// File: rtl/riskproc_pkg.sv
// riskproc_pkg: shared register-file defaults, types and the zero-register index
package riskproc_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with r0 zeroing, byte-merge write forwarding and busy alignment
module regfile_rd_port import riskproc_pkg::*; #(
  parameter int XLEN = riskproc_pkg::XLEN,
  parameter int AW = riskproc_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] wbe_i,
  input  logic [XLEN-1:0]   rword_i,
  input  logic              busy_nx_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              busy_o
);
  logic [XLEN-1:0] merged, rdata_d, rdata_q;
  logic busy_d, busy_q, zero;
  always_comb begin
    merged = rword_i;
    for (int i = 0; i < XLEN/8; i++)
      if (wbe_i[i]) merged[8*i +: 8] = wdata_i[8*i +: 8];
  end
  assign zero = raddr_i == AW'(REG_ZERO);
  assign rdata_d = zero ? '0 : (we_i && waddr_i == raddr_i) ? merged : rword_i;
  assign busy_d = !zero && busy_nx_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      busy_q <= busy_d;
    end
  end
  assign rdata_o = rdata_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: byte-enabled register file, two forwarding read ports, per-register busy scoreboard
module regfile_sb import riskproc_pkg::*; #(
  parameter int XLEN = riskproc_pkg::XLEN,
  parameter int NREGS = riskproc_pkg::NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN/8-1:0] wbe,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  output logic              any_busy
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic any_q, wr, set;
  assign wr = we && waddr != AW'(REG_ZERO);
  assign set = set_en && set_addr != AW'(REG_ZERO);
  always_comb begin
    busy_d = busy_q;
    if (wr) busy_d[waddr] = 1'b0;
    if (set) busy_d[set_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      any_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      any_q <= |busy_d;
      if (wr)
        for (int i = 0; i < XLEN/8; i++)
          if (wbe[i]) regs_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
  assign any_busy = any_q;
  regfile_rd_port #(.XLEN(XLEN), .AW(AW)) u_rd_a (
    .clk(clk), .rst(reset), .raddr_i(raddr_a), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .wbe_i(wbe), .rword_i(regs_q[raddr_a]), .busy_nx_i(busy_d[raddr_a]),
    .rdata_o(rdata_a), .busy_o(busy_a)
  );
  regfile_rd_port #(.XLEN(XLEN), .AW(AW)) u_rd_b (
    .clk(clk), .rst(reset), .raddr_i(raddr_b), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .wbe_i(wbe), .rword_i(regs_q[raddr_b]), .busy_nx_i(busy_d[raddr_b]),
    .rdata_o(rdata_b), .busy_o(busy_b)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors with a queued scoreboard checked by an independent monitor
module tb_regfile_sb;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, set_en = 1'b0;
  logic [4:0] waddr = '0, raddr_a = '0, raddr_b = '0, set_addr = '0;
  logic [31:0] wdata = '0, rdata_a, rdata_b;
  logic [3:0] wbe = '0;
  logic busy_a, busy_b, any_busy;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {
    int due;
    string name;
    logic [4:0] m;
    logic [31:0] a, b;
    logic ba, bb, an;
  } exp_t;
  exp_t q[$];
  exp_t e;
  regfile_sb dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b), .set_en(set_en), .set_addr(set_addr), .any_busy(any_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.m[0]) chk({e.name, ".rdata_a"}, rdata_a, e.a);
      if (e.m[1]) chk({e.name, ".rdata_b"}, rdata_b, e.b);
      if (e.m[2]) chk({e.name, ".busy_a"}, {31'd0, busy_a}, {31'd0, e.ba});
      if (e.m[3]) chk({e.name, ".busy_b"}, {31'd0, busy_b}, {31'd0, e.bb});
      if (e.m[4]) chk({e.name, ".any_busy"}, {31'd0, any_busy}, {31'd0, e.an});
    end
  end
  task automatic drv(logic r, logic w, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                     logic [4:0] ra, logic [4:0] rb, logic s, logic [4:0] sa);
    @(negedge clk);
    reset = r; we = w; waddr = wa; wdata = wd; wbe = be;
    raddr_a = ra; raddr_b = rb; set_en = s; set_addr = sa;
  endtask
  task automatic expect_(string n, logic [4:0] m, logic [31:0] a, logic [31:0] b,
                         logic ba, logic bb, logic an);
    exp_t x;
    x.due = cyc + 1; x.name = n; x.m = m; x.a = a; x.b = b; x.ba = ba; x.bb = bb; x.an = an;
    q.push_back(x);
  endtask
  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("init_reset", 5'h1F, 0, 0, 0, 0, 0);
    drv(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 5, 5, 0, 0);
    expect_("reset_out", 5'h1F, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 5, 0, 0, 0);
    expect_("reset_r5", 5'h15, 0, 0, 0, 0, 0);
    drv(0, 1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0);
    drv(0, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 3, 3, 0, 0);
    expect_("byte_en", 5'h03, 32'h11BB33DD, 32'h11BB33DD, 0, 0, 0);
    drv(0, 1, 3, 32'h99887766, 4'b1000, 3, 0, 0, 0);
    expect_("fwd_partial", 5'h05, 32'h99BB33DD, 0, 0, 0, 0);
    drv(0, 1, 7, 32'h0000CAFE, 4'hF, 7, 7, 0, 0);
    expect_("fwd_full", 5'h0F, 32'h0000CAFE, 32'h0000CAFE, 0, 0, 0);
    drv(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 0);
    expect_("zero_wr", 5'h1F, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("zero_rd", 5'h15, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 9, 0, 1, 9);
    expect_("sb_set_same", 5'h14, 0, 0, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0);
    expect_("sb_busy", 5'h14, 0, 0, 1, 0, 1);
    drv(0, 1, 9, 32'h42, 4'hF, 9, 0, 0, 0);
    expect_("sb_clear", 5'h15, 32'h42, 0, 0, 0, 0);
    drv(0, 1, 9, 32'h55, 4'hF, 9, 9, 1, 9);
    expect_("sb_set_wins", 5'h1F, 32'h55, 32'h55, 1, 1, 1);
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0);
    expect_("sb_still", 5'h15, 32'h55, 0, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 12, 0, 1, 12);
    expect_("r12_set", 5'h14, 0, 0, 1, 0, 1);
    drv(1, 1, 12, 32'h5, 4'hF, 12, 9, 0, 0);
    expect_("mid_reset", 5'h1F, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 12, 9, 0, 0);
    expect_("after_reset", 5'h1F, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 20);
    expect_("r20_set", 5'h10, 0, 0, 0, 0, 1);
    drv(0, 1, 20, 32'hFFFF, 4'h0, 20, 0, 0, 0);
    expect_("wbe0_clear", 5'h15, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with byte-enabled writes and two registered read ports. It forwards same-cycle writes to the read ports and includes a per-register busy scoreboard for multi-cycle producers. It replaces the fixed 32x32 register array of hard-wired registers. It sits between the decode/issue stage, which reads and sets busy, and the writeback stage, which writes and clears busy. Register 0 is hard-wired to zero.

Parameters:
XLEN, 32, data width in bits; must be a multiple of 8.
NREGS, 32, number of architectural registers; a power of 2, at least 2.
AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous reset, active-high.
we  input  1  write enable (writeback).
waddr  input  AW  write register index.
wdata  input  XLEN  write data.
wbe  input  XLEN/8  write byte enables; bit i covers wdata[8i+7:8i].
raddr_a  input  AW  read port A index.
raddr_b  input  AW  read port B index.
rdata_a  output  XLEN  read data A, registered.
rdata_b  output  XLEN  read data B, registered.
busy_a  output  1  register raddr_a had a pending producer, registered with rdata_a.
busy_b  output  1  same, for port B.
set_en  input  1  mark set_addr busy (issue of a multi-cycle op).
set_addr  input  AW  register to mark busy.
any_busy  output  1  OR of all busy bits, registered.

Behaviour:
- Reset is synchronous and active-high. When reset=1 at a rising edge:
  - all registers become 0 and all busy bits become 0;
  - rdata_a, rdata_b, busy_a, busy_b and any_busy become 0;
  - a we or set_en presented in the same cycle is discarded.
- Write: if we=1 and waddr!=0, then for each i with wbe[i]=1, reg[waddr] byte i <= wdata byte i. Bytes with wbe[i]=0 keep their value. wbe=0 with we=1 is a legal no-op for data but still clears busy.
- Register 0 always holds 0. Writes to it are ignored and busy[0] is never set.
- Reads have 1-cycle latency. rdata_x at edge n+1 reflects raddr_x sampled at edge n.
  - If raddr_x==0: rdata_x <= 0.
  - Else if we=1 and waddr==raddr_x in the same cycle: rdata_x <= merged value (enabled bytes from wdata, other bytes from stored reg). This is write-first forwarding.
  - Otherwise: rdata_x <= reg[raddr_x].
  - Ports A and B are independent; the same address on both returns identical data.
- Scoreboard: one busy bit per register, evaluated at each edge.
  - Clear: we=1 and waddr!=0 clears busy[waddr].
  - Set: set_en=1 and set_addr!=0 sets busy[set_addr].
  - Set and clear to the same address in one cycle: set wins (a new producer supersedes the old one); busy stays 1.
  - Set of an already-busy register: stays 1, no error.
  - Write to a non-busy register: legal; busy stays 0.
- busy_x is registered and aligned with rdata_x. busy_x <= 0 if raddr_x==0. Otherwise busy_x <= next-state busy[raddr_x], i.e. it includes same-cycle set and clear:
  - a same-cycle clear with no set reports 0, because the data is forwarded;
  - a same-cycle set reports 1.
- any_busy <= OR of the next-state busy bits.
- No stalls and no handshake. Every port is sampled every cycle and consumers decide on busy_x.

Decomposition:
- Shared package riskproc_pkg holds:
  - XLEN and NREGS defaults;
  - typedef reg_addr_t (logic [AW-1:0]) and typedef xword_t (logic [XLEN-1:0]);
  - constant REG_ZERO = 0.
- One sub-module, regfile_rd_port, holds a single registered read port: zero-check, byte-merge forwarding and busy alignment. It is instantiated twice (A and B).
- Storage, write logic and the busy vector live in the top module.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, then assert reset 1 cycle, then read r5 -> rdata_a=0, busy_a=0, any_busy=0.
- Write/read with byte enables: write r3=32'h11223344 with wbe=4'hF, then write wdata=32'hAABBCCDD with wbe=4'b0101 -> r3 reads 32'h11BB33DD one cycle after raddr.
- Forwarding: raddr_a=7 and raddr_b=7 in the same cycle as we=1, waddr=7, wdata=32'h0000CAFE, wbe=4'hF (r7 previously 0) -> next cycle rdata_a=rdata_b=32'h0000CAFE.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF; set_en=1, set_addr=0 -> reading r0 gives 0, busy_a=0, any_busy unchanged.
- Scoreboard:
  - set_en on r9, then read r9 -> busy_a=1 and any_busy=1;
  - next, we on r9 with raddr_a=9 -> busy_a=0 and any_busy=0;
  - then set_en and we on r9 in one cycle -> busy stays 1.
- Reset mid-operation: r12 busy and we=1, waddr=12, wdata=5 asserted in the same cycle as reset -> r12=0, busy[12]=0, rdata outputs 0 on the next cycle.
